// File: rtl/miss_block_filler.sv
// Instruction-cache miss fill engine: takes one miss, requests its block from memory,
// and assembles the returned beats into a full cache block for the extraction stage.
module miss_block_filler #(
    parameter int ADDR_WIDTH = 16,
    parameter int BEAT_WIDTH = 80
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_miss_valid,
    input  logic [ADDR_WIDTH-1:0]   i_miss_addr,
    output logic                    o_miss_ready,
    output logic                    o_mem_req_valid,
    output logic [ADDR_WIDTH-5:0]   o_mem_req_addr,
    input  logic                    i_mem_req_ready,
    input  logic                    i_mem_beat_valid,
    input  logic [BEAT_WIDTH-1:0]   i_mem_beat_data,
    output logic [319:0]            o_block_data,
    output logic [3:0]              o_block_offset,
    output logic [ADDR_WIDTH-5:0]   o_block_addr,
    output logic                    o_valid,
    input  logic                    i_out_ready
);
    localparam int BLOCK_WIDTH = 320;
    localparam int NUM_BEATS   = BLOCK_WIDTH / BEAT_WIDTH;
    localparam int CNT_WIDTH   = 2;

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [CNT_WIDTH-1:0]    cnt_reg;
    logic [ADDR_WIDTH-5:0]   addr_reg;
    logic [3:0]              offset_reg;
    logic                    active_reg;
    logic [BEAT_WIDTH-1:0]   slice_reg [NUM_BEATS];

    logic miss_ready;
    logic req_valid;
    logic block_valid;
    logic accept;
    logic req_taken;
    logic take_beat;

    always_comb begin
        state_next  = state_reg;
        miss_ready  = 1'b0;
        req_valid   = 1'b0;
        block_valid = 1'b0;
        accept      = 1'b0;
        req_taken   = 1'b0;
        take_beat   = 1'b0;
        case (state_reg)
            IDLE: begin
                // active_reg keeps ready low through the reset cycles without a path from i_rst_n
                miss_ready = active_reg;
                accept     = i_miss_valid && active_reg;
                if (accept) state_next = REQ;
            end
            REQ: begin
                req_valid = 1'b1;
                req_taken = i_mem_req_ready;
                if (req_taken) state_next = FILL;
            end
            FILL: begin
                take_beat = i_mem_beat_valid;
                if (take_beat && cnt_reg == CNT_WIDTH'(NUM_BEATS - 1)) state_next = DONE;
            end
            DONE: begin
                block_valid = 1'b1;
                if (i_out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            addr_reg   <= '0;
            offset_reg <= '0;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            active_reg <= 1'b1;
            if (accept) begin
                addr_reg   <= i_miss_addr[ADDR_WIDTH-1:4];
                offset_reg <= i_miss_addr[3:0];
            end
            if (req_taken)
                cnt_reg <= '0;
            else if (take_beat)
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // One register slice per beat position; beat k carries words 4k..4k+3.
    generate
        for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_slice
            always_ff @(posedge i_clk) begin
                if (!i_rst_n)
                    slice_reg[gi] <= '0;
                else if (take_beat && cnt_reg == CNT_WIDTH'(gi))
                    slice_reg[gi] <= i_mem_beat_data;
            end
            assign o_block_data[gi*BEAT_WIDTH +: BEAT_WIDTH] = slice_reg[gi];
        end
    endgenerate

    assign o_miss_ready    = miss_ready;
    assign o_mem_req_valid = req_valid;
    assign o_mem_req_addr  = addr_reg;
    assign o_block_addr    = addr_reg;
    assign o_block_offset  = offset_reg;
    assign o_valid         = block_valid;

endmodule
